// File: rtl/reduce_tree_pipe_pkg.sv
// Shared types and elaboration helpers for the pipelined reduction tree.
// Optional feature macro used by the top: REDUCE_TREE_PIPE_TAG_EN (sideband tag).
package reduce_tree_pipe_pkg;

  typedef enum logic [1:0] {
    OpAnd = 2'd0,
    OpOr  = 2'd1,
    OpXor = 2'd2,
    OpMix = 2'd3
  } op_e;

  // Number of halving levels needed to fold a word down to one bit.
  function automatic int unsigned calc_levels(int unsigned width);
    return $clog2(width);
  endfunction

  // Input register plus one register per group of STAGE_EVERY levels.
  function automatic int unsigned calc_nstage(int unsigned levels, int unsigned stage_every);
    return 1 + (levels + stage_every - 1) / stage_every;
  endfunction

  // Tree level whose output a given pipeline register holds (0 = raw input word).
  function automatic int unsigned stage_level(int unsigned stage, int unsigned stage_every,
                                              int unsigned levels);
    int unsigned lv;
    lv = stage * stage_every;
    return (lv > levels) ? levels : lv;
  endfunction

  // Effective per-level operator; MIX cycles AND, XOR, OR, XOR from level 1 onward.
  function automatic op_e level_op(op_e op, int unsigned level);
    op_e eff;
    eff = op;
    if (op == OpMix) begin
      case ((level - 1) % 4)
        0:       eff = OpAnd;
        1:       eff = OpXor;
        2:       eff = OpOr;
        default: eff = OpXor;
      endcase
    end
    return eff;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_level.sv
// One combinational fold level: upper half combined bitwise with lower half.
module reduce_tree_pipe_level
  import reduce_tree_pipe_pkg::*;
#(
  parameter int unsigned IN_W = 2
) (
  input  logic [IN_W-1:0]   data_i,
  input  op_e               op_i,
  output logic [IN_W/2-1:0] data_o
);

  localparam int unsigned HalfW = IN_W / 2;

  logic [HalfW-1:0] hi;
  logic [HalfW-1:0] lo;

  // Fold the two halves with the already-resolved per-level operator.
  always_comb begin
    hi = data_i[IN_W-1:HalfW];
    lo = data_i[HalfW-1:0];
    case (op_i)
      OpAnd:   data_o = hi & lo;
      OpOr:    data_o = hi | lo;
      default: data_o = hi ^ lo;  // OpMix is resolved before reaching a level
    endcase
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined bitwise reduction tree with valid/ready and a global stall.
// Define REDUCE_TREE_PIPE_TAG_EN to add the in_tag/out_tag sideband and its pipeline.
module reduce_tree_pipe
  import reduce_tree_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STAGE_EVERY = 2
`ifdef REDUCE_TREE_PIPE_TAG_EN
  ,
  parameter int unsigned TAG_W       = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data
`ifdef REDUCE_TREE_PIPE_TAG_EN
  ,
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag
`endif
);

  localparam int unsigned LEVELS = calc_levels(WIDTH);
  localparam int unsigned NSTAGE = calc_nstage(LEVELS, STAGE_EVERY);

  logic              adv;
  logic [NSTAGE-1:0] vld_d, vld_q;
  // The last register holds only the result bit, so op stops one stage early.
  op_e               op_d [NSTAGE-1];
  op_e               op_q [NSTAGE-1];

  // Valid bits and op shift one stage per advance; bubbles travel like words.
  always_comb begin
    vld_d = {vld_q[NSTAGE-2:0], in_valid};
    op_d  = op_q;
    op_d[0] = op_e'(in_op);
    for (int s = 1; s < NSTAGE - 1; s++) begin
      op_d[s] = op_q[s-1];
    end
  end

  // Control pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      op_q  <= '{default: OpAnd};
    end else if (adv) begin
      vld_q <= vld_d;
      op_q  <= op_d;
    end
  end

  // Data registers; each holds the output of a specific tree level.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_stg
    localparam int unsigned LV = stage_level(s, STAGE_EVERY, LEVELS);
    localparam int unsigned SW = WIDTH >> LV;

    logic [SW-1:0] data_d, data_q;

    if (s == 0) begin : g_src
      // Stage 0 captures the raw word.
      always_comb data_d = in_data;
    end else begin : g_src
      // Later stages capture the last level of their group.
      always_comb data_d = g_lvl[LV].fold;
    end

    // Stage register; loads only when the whole pipe advances.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (adv) begin
        data_q <= data_d;
      end
    end
  end

  // Combinational levels; a level reads a register when it opens a new group.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned IW  = WIDTH >> (l - 1);
    localparam int unsigned SRC = (l - 1) / STAGE_EVERY;

    logic [IW-1:0]   vin;
    logic [IW/2-1:0] fold;
    op_e             lop;

    if (((l - 1) % STAGE_EVERY) == 0) begin : g_in
      // First level after a register.
      always_comb vin = g_stg[SRC].data_q;
    end else begin : g_in
      // Chained directly from the previous level.
      always_comb vin = g_lvl[l-1].fold;
    end

    // Resolve this level's operator from the word's own op.
    always_comb lop = level_op(op_q[SRC], l);

    reduce_tree_pipe_level #(
      .IN_W (IW)
    ) u_level (
      .data_i (vin),
      .op_i   (lop),
      .data_o (fold)
    );
  end

`ifdef REDUCE_TREE_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_d [NSTAGE];
  logic [TAG_W-1:0] tag_q [NSTAGE];

  // Tag shifts in lockstep with the data.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = in_tag;
    for (int s = 1; s < NSTAGE; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // Tag registers share the data stall and reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '{default: '0};
    end else if (adv) begin
      tag_q <= tag_d;
    end
  end

  assign out_tag = tag_q[NSTAGE-1];
`endif

  // Global stall: everything moves unless a result is held for the consumer.
  always_comb begin
    adv       = !vld_q[NSTAGE-1] || out_ready;
    in_ready  = adv;
    out_valid = vld_q[NSTAGE-1];
    out_data  = g_stg[NSTAGE-1].data_q[0];
  end

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench for reduce_tree_pipe; also exercises W8/S1 and W32/S3 instances.
module tb_reduce_tree_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SE    = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned LAT   = 1 + ($clog2(WIDTH) + SE - 1) / SE;

  typedef struct {
    bit               d;
    int               acc;
    bit               lat;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid, in_ready, out_valid, out_ready, out_data;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
`ifdef REDUCE_TREE_PIPE_TAG_EN
  logic [TAG_W-1:0] out_tag;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  int    force_exp = -1;
  bit    lat_en = 1'b1;
  bit    alt_go = 1'b0;
  item_t exp_q[$];
  bit    presenting = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reduce_tree_pipe #(
    .WIDTH       (WIDTH),
    .STAGE_EVERY (SE)
`ifdef REDUCE_TREE_PIPE_TAG_EN
    ,
    .TAG_W       (TAG_W)
`endif
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef REDUCE_TREE_PIPE_TAG_EN
    ,
    .in_tag    (in_tag),
    .out_tag   (out_tag)
`endif
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain reductions for fixed ops, explicit halving array for MIX.
  function automatic bit ref_reduce(logic [31:0] d, int op, int w);
    bit v[32];
    bit all1, any1, par, a, b;
    int n, lvl;
    all1 = 1'b1; any1 = 1'b0; par = 1'b0;
    for (int i = 0; i < w; i++) begin
      all1 &= d[i];
      any1 |= d[i];
      par  ^= d[i];
      v[i] = d[i];
    end
    if (op == 0) return all1;
    if (op == 1) return any1;
    if (op == 2) return par;
    n = w;
    lvl = 0;
    while (n > 1) begin
      n = n / 2;
      lvl++;
      for (int i = 0; i < n; i++) begin
        a = v[i+n];
        b = v[i];
        case ((lvl - 1) % 4)
          0:       v[i] = a & b;
          2:       v[i] = a | b;
          default: v[i] = a ^ b;
        endcase
      end
    end
    return v[0];
  endfunction

  // Monitor: checks held outputs against the queue head, then records new accepts.
  always @(negedge clk) begin
    if (rst) begin
      presenting = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!presenting) begin
            presenting = 1'b1;
            if (exp_q[0].lat) chk("latency", cyc - exp_q[0].acc, LAT);
          end
          chk("out_data", {31'd0, out_data}, {31'd0, exp_q[0].d});
`ifdef REDUCE_TREE_PIPE_TAG_EN
          chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
`endif
          if (!out_ready) chk("in_ready_while_stalled", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            presenting = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        item_t it;
        it.d   = (force_exp >= 0) ? force_exp[0] : ref_reduce(32'(in_data), in_op, WIDTH);
        it.acc = cyc;
        it.lat = lat_en;
        it.tag = in_tag;
        exp_q.push_back(it);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until taken; returns at posedge+1 after the accept.
  task automatic send(logic [WIDTH-1:0] d, logic [1:0] op, int fexp);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    in_data   = d;
    in_op     = op;
    in_tag    = TAG_W'($urandom());
    force_exp = fexp;
    forever begin
      @(negedge clk);
      if (in_ready || guard > 200) break;
      guard++;
      tick();
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  task automatic drain(string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      tick();
      g++;
    end
    chk({name, "_left_in_queue"}, exp_q.size(), 0);
  endtask

  task automatic run_random(int n, bit bp);
    int sent, guard;
    bit have;
    sent = 0; guard = 0; have = 1'b0;
    force_exp = -1;
    while (sent < n && guard < 20000) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!have) begin
        if ($urandom_range(0, 2) != 0) begin
          have     = 1'b1;
          in_valid = 1'b1;
          in_data  = WIDTH'($urandom());
          in_op    = 2'($urandom());
          in_tag   = TAG_W'($urandom());
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (have && in_ready) begin
        have = 1'b0;
        sent++;
      end
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sent < n) chk("random_stream_stalled", sent, n);
  endtask

  // Alternate geometries with out_ready tied high: fixed latency, model-checked data.
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int unsigned AW   = (g == 0) ? 8 : 32;
    localparam int unsigned AS   = (g == 0) ? 1 : 3;
    localparam int unsigned ALAT = (g == 0) ? 4 : 3;

    logic             a_iv, a_ir, a_ov, a_od;
    logic [AW-1:0]    a_id;
    logic [1:0]       a_op;
    logic [TAG_W-1:0] a_it;
`ifdef REDUCE_TREE_PIPE_TAG_EN
    logic [TAG_W-1:0] a_ot;
`endif
    bit               done = 1'b0;
    item_t            q[$];

    reduce_tree_pipe #(
      .WIDTH       (AW),
      .STAGE_EVERY (AS)
`ifdef REDUCE_TREE_PIPE_TAG_EN
      ,
      .TAG_W       (TAG_W)
`endif
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_iv),
      .in_ready  (a_ir),
      .in_data   (a_id),
      .in_op     (a_op),
      .out_valid (a_ov),
      .out_ready (1'b1),
      .out_data  (a_od)
`ifdef REDUCE_TREE_PIPE_TAG_EN
      ,
      .in_tag    (a_it),
      .out_tag   (a_ot)
`endif
    );

    initial begin
      a_iv = 1'b0; a_id = '0; a_op = '0; a_it = '0;
      wait (alt_go);
      @(posedge clk);
      #1;
      repeat (80) begin
        a_iv = 1'($urandom_range(0, 1));
        a_id = AW'($urandom());
        a_op = 2'($urandom());
        a_it = TAG_W'($urandom());
        @(posedge clk);
        #1;
      end
      a_iv = 1'b0;
      repeat (ALAT + 4) @(posedge clk);
      done = 1'b1;
    end

    always @(negedge clk) begin
      if (!rst) begin
        if (a_ov) begin
          if (q.size() == 0) begin
            chk("alt_spurious_out_valid", {31'd0, a_ov}, 32'd0);
          end else begin
            chk($sformatf("alt%0d_latency", AW), cyc - q[0].acc, ALAT);
            chk($sformatf("alt%0d_out_data", AW), {31'd0, a_od}, {31'd0, q[0].d});
`ifdef REDUCE_TREE_PIPE_TAG_EN
            chk($sformatf("alt%0d_out_tag", AW), 32'(a_ot), 32'(q[0].tag));
`endif
            void'(q.pop_front());
          end
        end
        if (a_iv && a_ir) begin
          item_t it;
          it.d   = ref_reduce(32'(a_id), a_op, AW);
          it.acc = cyc;
          it.lat = 1'b1;
          it.tag = a_it;
          q.push_back(it);
        end
      end
    end
  end

  initial begin
    int g;
    in_valid = 1'b0; in_data = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {31'd0, out_data}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // MIX example with latency
    send(16'h0101, 2'd3, 1);
    in_valid = 1'b0; force_exp = -1;
    drain("t1");

    // Fixed-op corner words
    send(16'hFFFF, 2'd0, 1);
    send(16'hFFFE, 2'd0, 0);
    send(16'h0000, 2'd1, 0);
    send(16'h8000, 2'd1, 1);
    send(16'h0007, 2'd2, 1);
    send(16'h0003, 2'd2, 0);
    in_valid = 1'b0; force_exp = -1;
    drain("t2");

    // Back-to-back mixed ops
    for (int i = 0; i < 8; i++) send(WIDTH'($urandom()), 2'(i % 4), -1);
    in_valid = 1'b0;
    drain("t3");

    // Backpressure window in the middle of a stream
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(WIDTH'($urandom()), 2'($urandom()), -1);
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    drain("t4");

    // Reset with two words in flight
    send(WIDTH'($urandom()), 2'($urandom()), -1);
    send(WIDTH'($urandom()), 2'($urandom()), -1);
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    repeat (8) tick();
    drain("t5");

    // Random streams: with and without backpressure
    run_random(150, 1'b1);
    drain("rand_bp");
    lat_en = 1'b1;
    run_random(60, 1'b0);
    drain("rand_nobp");

    // Alternate geometries
    alt_go = 1'b1;
    g = 0;
    while (!(g_alt[0].done && g_alt[1].done) && g < 3000) begin
      tick();
      g++;
    end
    chk("alt_finished", {31'd0, (g_alt[0].done && g_alt[1].done)}, 32'd1);
    chk("alt_left_in_queue", g_alt[0].q.size() + g_alt[1].q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
